serial_pattern_gen: RTL and testbench

//  Serial bit-pattern transmitter that drives a 1-bit serial data line one bit per clock.
//  It emits a PAT_W-bit pattern MSB-first, Repeat times, with GAP_LEN zero bits between

---
 rtl/serial_pattern_gen_if.sv | 16 +
 rtl/serial_pattern_gen.sv | 84 ++++++++
 tb/tb_serial_pattern_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_gen_if.sv
// serial_pattern_gen_if: control/pattern inputs and serial outputs of the pattern transmitter
interface serial_pattern_gen_if #(
    parameter int PAT_W = 3,
    parameter int RPT_W = 4
);
    logic             start;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic [RPT_W-1:0] rpt;
    logic             dout;
    logic             valid;
    logic             busy;
    logic             done;
    modport master (output start, load, pat_in, rpt, input dout, valid, busy, done);
    modport slave  (input start, load, pat_in, rpt, output dout, valid, busy, done);
endinterface

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: sends a PAT_W-bit pattern MSB-first rpt times with GAP_LEN zero bits between repeats
module serial_pattern_gen #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               GAP_LEN = 1,
    parameter int               RPT_W   = 4
) (
    input logic                clk,
    input logic                rst_n,
    serial_pattern_gen_if.slave bus
);
    localparam int BW = $clog2(PAT_W);
    localparam int GW = GAP_LEN > 1 ? $clog2(GAP_LEN) : 1;
    localparam logic [BW-1:0] BIT_TOP  = BW'(PAT_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [RPT_W-1:0] rem_q, rem_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             dout_q, valid_q, busy_q, done_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= PATTERN;
            bit_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            // outputs are decoded from the current state and registered, so they trail the state by one cycle
            dout_q  <= state_q == SEND && pat_q[bit_q];
            valid_q <= state_q == SEND || state_q == GAP;
            busy_q  <= state_q == SEND || state_q == GAP;
            done_q  <= state_q == DONE;
        end
    end
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                pat_d = bus.load ? bus.pat_in : pat_q;
                if (bus.start) begin
                    rem_d   = bus.rpt;
                    bit_d   = BIT_TOP;
                    state_d = bus.rpt != '0 ? SEND : DONE;
                end
            end
            SEND: begin
                if (bit_q == '0) begin
                    rem_d = rem_q - RPT_W'(1);
                    bit_d = BIT_TOP;
                    gap_d = '0;
                    state_d = rem_q == RPT_W'(1) ? DONE : (GAP_LEN > 0 ? GAP : SEND);
                end else begin
                    bit_d = bit_q - BW'(1);
                end
            end
            GAP: begin
                gap_d   = gap_q + GW'(1);
                bit_d   = BIT_TOP;
                state_d = gap_q == GAP_LAST ? SEND : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: randomized and directed bursts checked against a bit-list model of the transmitter
module tb_serial_pattern_gen;
    localparam int PAT_W = 3, GAP_LEN = 1, RPT_W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    serial_pattern_gen_if #(.PAT_W(PAT_W), .RPT_W(RPT_W)) bus ();
    serial_pattern_gen #(.PAT_W(PAT_W), .PATTERN(3'b101), .GAP_LEN(GAP_LEN), .RPT_W(RPT_W))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_cmp = 0, n_err = 0;
    logic [PAT_W-1:0] model_pat = 3'b101;
    // per-cycle vectors {valid, dout, busy, done}
    logic [3:0] exp4[$], obs4[$];
    task automatic build_exp(input logic [PAT_W-1:0] p, input int r, input int tail);
        exp4.delete();
        for (int k = 0; k < r; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp4.push_back({1'b1, p[b], 1'b1, 1'b0});
            if (k < r - 1) for (int g = 0; g < GAP_LEN; g++) exp4.push_back(4'b1010);
        end
        exp4.push_back(4'b0001);
        for (int t = 0; t < tail; t++) exp4.push_back(4'b0000);
    endtask
    task automatic kick(input bit ld, input logic [PAT_W-1:0] p, input int r);
        bus.load = ld;
        bus.pat_in = p;
        bus.rpt = RPT_W'(r);
        bus.start = 1'b1;
        if (ld) model_pat = p;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.load = 1'b0;
    endtask
    task automatic capture(input int noise_a, input int noise_b);
        obs4.delete();
        for (int i = 0; i < exp4.size(); i++) begin
            @(posedge clk); #1;
            obs4.push_back({bus.valid, bus.dout, bus.busy, bus.done});
            bus.start = (i == noise_a || i == noise_b);
            bus.load = bus.start;
            if (bus.start) begin
                bus.pat_in = PAT_W'($urandom);
                bus.rpt = RPT_W'($urandom_range(1, 15));
            end
        end
        bus.start = 1'b0;
        bus.load = 1'b0;
    endtask
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 n_cmp++;
        if ({bus.valid, bus.dout, bus.busy, bus.done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold {v,d,b,done} got %b want 0000", {bus.valid, bus.dout, bus.busy, bus.done});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 n_cmp++;
        if ({bus.valid, bus.dout, bus.busy, bus.done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_idle {v,d,b,done} got %b want 0000", {bus.valid, bus.dout, bus.busy, bus.done});
        end
    endtask
    task automatic test_default_burst();
        kick(1'b0, '0, 2);
        build_exp(model_pat, 2, 2);
        capture(-1, -1);
        for (int i = 0; i < exp4.size(); i++) begin
            n_cmp++;
            if (obs4[i] !== exp4[i]) begin
                n_err++;
                $display("FAIL default_burst cyc %0d {v,d,b,done} got %b want %b", i, obs4[i], exp4[i]);
            end
        end
    endtask
    task automatic test_load_then_start();
        bus.load = 1'b1;
        bus.pat_in = 3'b110;
        model_pat = 3'b110;
        @(posedge clk); #1 bus.load = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            kick(1'b0, 3'b000, 1);
            build_exp(model_pat, 1, 1);
            capture(-1, -1);
            for (int i = 0; i < exp4.size(); i++) begin
                n_cmp++;
                if (obs4[i] !== exp4[i]) begin
                    n_err++;
                    $display("FAIL load_then_start run %0d cyc %0d got %b want %b", rep, i, obs4[i], exp4[i]);
                end
            end
        end
    endtask
    task automatic test_load_with_start();
        kick(1'b1, 3'b011, 1);
        build_exp(model_pat, 1, 1);
        capture(-1, -1);
        for (int i = 0; i < exp4.size(); i++) begin
            n_cmp++;
            if (obs4[i] !== exp4[i]) begin
                n_err++;
                $display("FAIL load_with_start cyc %0d got %b want %b", i, obs4[i], exp4[i]);
            end
        end
    endtask
    task automatic test_zero_repeat();
        kick(1'b0, 3'b000, 0);
        build_exp(model_pat, 0, 2);
        capture(-1, -1);
        for (int i = 0; i < exp4.size(); i++) begin
            n_cmp++;
            if (obs4[i] !== exp4[i]) begin
                n_err++;
                $display("FAIL zero_repeat cyc %0d got %b want %b", i, obs4[i], exp4[i]);
            end
        end
    endtask
    task automatic test_ignore_midburst();
        kick(1'b0, 3'b000, 3);
        build_exp(model_pat, 3, 4);
        capture(2, 3 * PAT_W + 2 * GAP_LEN - 1);
        for (int i = 0; i < exp4.size(); i++) begin
            n_cmp++;
            if (obs4[i] !== exp4[i]) begin
                n_err++;
                $display("FAIL ignore_midburst cyc %0d got %b want %b", i, obs4[i], exp4[i]);
            end
        end
    endtask
    task automatic test_back_to_back();
        for (int it = 0; it < 12; it++) begin
            int r;
            r = $urandom_range(0, 5);
            kick(1'($urandom_range(0, 1)), PAT_W'($urandom), r);
            build_exp(model_pat, r, 0);
            capture(-1, -1);
            for (int i = 0; i < exp4.size(); i++) begin
                n_cmp++;
                if (obs4[i] !== exp4[i]) begin
                    n_err++;
                    $display("FAIL back_to_back it %0d pat %b rpt %0d cyc %0d got %b want %b", it, model_pat, r, i, obs4[i], exp4[i]);
                end
            end
        end
        @(posedge clk); #1 n_cmp++;
        if ({bus.valid, bus.dout, bus.busy, bus.done} !== 4'b0000) begin
            n_err++;
            $display("FAIL back_to_back_idle got %b want 0000", {bus.valid, bus.dout, bus.busy, bus.done});
        end
    endtask
    task automatic test_async_reset();
        kick(1'b1, 3'b111, 3);
        repeat (2) @(posedge clk);
        #1 n_cmp++;
        if ({bus.valid, bus.dout, bus.busy, bus.done} !== 4'b1110) begin
            n_err++;
            $display("FAIL areset_pre got %b want 1110", {bus.valid, bus.dout, bus.busy, bus.done});
        end
        #2 rst_n = 1'b0;
        model_pat = 3'b101;
        #1 n_cmp++;
        if ({bus.valid, bus.dout, bus.busy, bus.done} !== 4'b0000) begin
            n_err++;
            $display("FAIL areset_immediate got %b want 0000", {bus.valid, bus.dout, bus.busy, bus.done});
        end
        repeat (2) begin
            @(posedge clk); #1 n_cmp++;
            if ({bus.valid, bus.dout, bus.busy, bus.done} !== 4'b0000) begin
                n_err++;
                $display("FAIL areset_hold got %b want 0000", {bus.valid, bus.dout, bus.busy, bus.done});
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL areset_no_done got %b want 0", bus.done);
        end
        kick(1'b0, 3'b000, 1);
        build_exp(model_pat, 1, 1);
        capture(-1, -1);
        for (int i = 0; i < exp4.size(); i++) begin
            n_cmp++;
            if (obs4[i] !== exp4[i]) begin
                n_err++;
                $display("FAIL areset_pattern cyc %0d got %b want %b", i, obs4[i], exp4[i]);
            end
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 1'b0;
        bus.load = 1'b0;
        bus.pat_in = '0;
        bus.rpt = '0;
        test_reset();
        test_default_burst();
        test_load_then_start();
        test_load_with_start();
        test_zero_repeat();
        test_ignore_midburst();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
